// File: rtl/alu_result_fifo.sv
// Capture FIFO for 16-bit ALU results with first-word fall-through, overflow-event counter
// and optional sticky flag accumulator (enabled by defining STICKY_FLAGS_EN).
module alu_result_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_sum,
  input  logic                     in_zero,
  input  logic                     in_sign,
  input  logic                     in_carry,
  input  logic                     in_parity,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_sum,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNTW-1:0]          ovf_count,
  input  logic                     stat_clr,
  output logic [4:0]               sticky_flags
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  logic [DW-1:0]   r_sum_mem  [DEPTH];
  logic [4:0]      r_flag_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [CNTW-1:0] r_ovf_count;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [4:0] w_in_flags;

  assign w_in_flags = {in_overflow, in_parity, in_carry, in_sign, in_zero};
  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  // Full blocks pushes even when a pop happens in the same cycle.
  assign w_push     = in_valid & ~w_full;
  assign w_pop      = out_ready & ~w_empty;

  // NOTE: the storage array has no reset; out_valid masks stale entries, so
  // clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sum_mem[r_wr_ptr]  <= in_sum;
      r_flag_mem[r_wr_ptr] <= w_in_flags;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear wins over increment, but a concurrent overflow push still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_count <= '0;
    end else if (stat_clr) begin
      r_ovf_count <= (w_push && in_overflow) ? CNTW'(1) : '0;
    end else if (w_push && in_overflow && (r_ovf_count != CNT_MAX)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [4:0] r_sticky;
  logic [4:0] w_new_flags;

  assign w_new_flags = w_push ? w_in_flags : 5'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sticky <= '0;
    else if (stat_clr) r_sticky <= w_new_flags;
    else               r_sticky <= r_sticky | w_new_flags;
  end

  assign sticky_flags = r_sticky;
`else
  assign sticky_flags = 5'b0;
`endif

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_sum   = w_empty ? '0 : r_sum_mem[r_rd_ptr];
  assign out_flags = w_empty ? '0 : r_flag_mem[r_rd_ptr];
  assign level     = r_level;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed table, hand sequences for
// saturation/sticky/reset corners, and a randomized run against a queue model.
module tb_alu_result_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int CMAX  = (1 << CNTW) - 1;
`ifdef STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_sum = '0;
  logic          in_zero = 1'b0, in_sign = 1'b0, in_carry = 1'b0;
  logic          in_parity = 1'b0, in_overflow = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sum;
  logic [4:0]    out_flags;
  logic [2:0]    level;
  logic [CNTW-1:0] ovf_count;
  logic          stat_clr = 1'b0;
  logic [4:0]    sticky_flags;

  int n_pass  = 0;
  int n_total = 0;

  alu_result_fifo #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_zero(in_zero), .in_sign(in_sign), .in_carry(in_carry),
    .in_parity(in_parity), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags), .level(level),
    .ovf_count(ovf_count), .stat_clr(stat_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags are {ovf,parity,carry,sign,zero}
  task automatic drive(input logic v, input logic [DW-1:0] s, input logic [4:0] f);
    in_valid    = v;
    in_sum      = s;
    in_overflow = f[4];
    in_parity   = f[3];
    in_carry    = f[2];
    in_sign     = f[1];
    in_zero     = f[0];
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_sum"},   32'(out_sum),   32'd0);
    check({tag, "_out_flags"}, 32'(out_flags), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] s;
    logic [4:0]    f;
    logic          ordy;
    int            lvl;
    logic          ir;
    logic          ov;
    logic [DW-1:0] osum;
    logic [4:0]    oflg;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic [4:0]    flags;
  } entry_t;

  vec_t   tbl [15];
  entry_t q [$];
  int     m_ovf;
  logic [4:0] m_sticky;

  initial begin
    // push/pop table: fill past full, pop-only when full, drain, empty pop, push+pop
    tbl[0]  = '{1'b1, 16'h1111, 5'h01, 1'b0, 1, 1'b1, 1'b1, 16'h1111, 5'h01};
    tbl[1]  = '{1'b1, 16'h2222, 5'h02, 1'b0, 2, 1'b1, 1'b1, 16'h1111, 5'h01};
    tbl[2]  = '{1'b1, 16'h3333, 5'h04, 1'b0, 3, 1'b1, 1'b1, 16'h1111, 5'h01};
    tbl[3]  = '{1'b1, 16'h4444, 5'h08, 1'b0, 4, 1'b0, 1'b1, 16'h1111, 5'h01};
    tbl[4]  = '{1'b1, 16'h5555, 5'h03, 1'b0, 4, 1'b0, 1'b1, 16'h1111, 5'h01};
    tbl[5]  = '{1'b1, 16'h6666, 5'h05, 1'b1, 3, 1'b1, 1'b1, 16'h2222, 5'h02};
    tbl[6]  = '{1'b1, 16'h7777, 5'h0C, 1'b0, 4, 1'b0, 1'b1, 16'h2222, 5'h02};
    tbl[7]  = '{1'b0, 16'hDEAD, 5'h1F, 1'b1, 3, 1'b1, 1'b1, 16'h3333, 5'h04};
    tbl[8]  = '{1'b0, 16'hBEEF, 5'h1F, 1'b1, 2, 1'b1, 1'b1, 16'h4444, 5'h08};
    tbl[9]  = '{1'b0, 16'h0000, 5'h00, 1'b1, 1, 1'b1, 1'b1, 16'h7777, 5'h0C};
    tbl[10] = '{1'b0, 16'h0000, 5'h00, 1'b1, 0, 1'b1, 1'b0, 16'h0000, 5'h00};
    tbl[11] = '{1'b0, 16'hFFFF, 5'h00, 1'b1, 0, 1'b1, 1'b0, 16'h0000, 5'h00};
    tbl[12] = '{1'b1, 16'hB001, 5'h01, 1'b1, 1, 1'b1, 1'b1, 16'hB001, 5'h01};
    tbl[13] = '{1'b1, 16'hB002, 5'h06, 1'b1, 1, 1'b1, 1'b1, 16'hB002, 5'h06};
    tbl[14] = '{1'b0, 16'h0000, 5'h00, 1'b1, 0, 1'b1, 1'b0, 16'h0000, 5'h00};

    // reset held with in_valid high
    drive(1'b1, 16'hABCD, 5'h1F);
    out_ready = 1'b1;
    do_reset();
    drive(1'b0, 16'h0, 5'h0);
    out_ready = 1'b0;
    check_empty("reset");
    check("reset_ovf_count", 32'(ovf_count), 32'd0);
    check("reset_sticky", 32'(sticky_flags), 32'd0);

    // single push of 0x8000 with ovf+sign; no same-cycle bypass
    drive(1'b1, 16'h8000, 5'b10010);
    #1;
    check("nobypass_out_valid", 32'(out_valid), 32'd0);
    step();
    drive(1'b0, 16'h0, 5'h0);
    check("push1_out_valid", 32'(out_valid), 32'd1);
    check("push1_out_sum",   32'(out_sum),   32'h8000);
    check("push1_out_flags", 32'(out_flags), 32'b10010);
    check("push1_ovf_count", 32'(ovf_count), 32'd1);
    check("push1_level",     32'(level),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_empty("pop1");

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].f);
      out_ready = tbl[i].ordy;
      step();
      check($sformatf("tbl%0d_level", i),     32'(level),     32'(tbl[i].lvl));
      check($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_out_sum", i),   32'(out_sum),   32'(tbl[i].osum));
      check($sformatf("tbl%0d_out_flags", i), 32'(out_flags), 32'(tbl[i].oflg));
    end
    drive(1'b0, 16'h0, 5'h0);

    // overflow counter saturation
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_ovf_count", 32'(ovf_count), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'(i), 5'b10000);
      step();
      if (i == 253 || i == 254 || i == 299)
        check($sformatf("sat_ovf_count_%0d", i + 1), 32'(ovf_count),
              32'((i + 1 > CMAX) ? CMAX : i + 1));
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    drive(1'b0, 16'h0, 5'h0);
    check("clr_with_push_ovf_count", 32'(ovf_count), 32'd1);
    step();
    check_empty("sat_drain");

    // sticky flags accumulate, clear, clear-with-push
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("sticky_pre_clr", 32'(sticky_flags), 32'd0);
    drive(1'b1, 16'h0101, 5'b00100);
    step();
    drive(1'b1, 16'h0000, 5'b00001);
    step();
    drive(1'b0, 16'h0, 5'h0);
    step();
    check("sticky_accum", 32'(sticky_flags), STICKY ? 32'b00101 : 32'd0);
    stat_clr = 1'b1;
    step();
    check("sticky_clr", 32'(sticky_flags), 32'd0);
    drive(1'b1, 16'h0202, 5'b00100);
    step();
    stat_clr = 1'b0;
    drive(1'b0, 16'h0, 5'h0);
    check("sticky_clr_push", 32'(sticky_flags), STICKY ? 32'b00100 : 32'd0);
    step();
    check_empty("sticky_drain");

    // asynchronous reset mid-transfer
    out_ready = 1'b0;
    drive(1'b1, 16'hCAFE, 5'h1F);
    step();
    step();
    check("pre_areset_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_empty("areset");
    check("areset_ovf_count", 32'(ovf_count), 32'd0);
    check("areset_sticky", 32'(sticky_flags), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 5'h0);
    out_ready = 1'b0;
    step();
    check_empty("post_areset");

    // randomized run against a queue model
    do_reset();
    q.delete();
    m_ovf    = 0;
    m_sticky = '0;
    for (int c = 0; c < 500; c++) begin
      logic          v, ordy, clr, push, pop;
      logic [DW-1:0] s;
      logic [4:0]    f, newf;
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 2) != 0;
      clr  = ($urandom % 32) == 0;
      s    = DW'($urandom);
      f    = 5'($urandom);
      drive(v, s, f);
      out_ready = ordy;
      stat_clr  = clr;
      push = v && (q.size() < DEPTH);
      pop  = ordy && (q.size() > 0);
      newf = push ? f : 5'b0;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{sum: s, flags: f});
      if (clr)                    m_ovf = (push && f[4]) ? 1 : 0;
      else if (push && f[4])      m_ovf = (m_ovf < CMAX) ? m_ovf + 1 : CMAX;
      m_sticky = clr ? newf : (m_sticky | newf);
      step();
      check("rnd_level",     32'(level),     32'(q.size()));
      check("rnd_in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("rnd_out_sum",   32'(out_sum),   (q.size() > 0) ? 32'(q[0].sum) : 32'd0);
      check("rnd_out_flags", 32'(out_flags), (q.size() > 0) ? 32'(q[0].flags) : 32'd0);
      check("rnd_ovf_count", 32'(ovf_count), 32'(m_ovf));
      check("rnd_sticky",    32'(sticky_flags), STICKY ? 32'(m_sticky) : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
